traffic_sequencer: RTL

//  Phase controller for a two-approach junction on PYNQ-Z2 RGB LEDs.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/traffic_sequencer_tick_gen.sv | 27 ++
 rtl/traffic_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes, phase encodings and the phase-to-lights decode
// used by the junction sequencer and its bench.
package traffic_pkg;

  localparam logic [2:0] LT_RED    = 3'd4;
  localparam logic [2:0] LT_GREEN  = 3'd2;
  localparam logic [2:0] LT_YELLOW = 3'd6;

  typedef enum logic [2:0] {
    S_G1   = 3'd0,
    S_Y1   = 3'd1,
    S_R1   = 3'd2,
    S_G2   = 3'd3,
    S_Y2   = 3'd4,
    S_R2   = 3'd5,
    S_WALK = 3'd6
  } state_t;

  // Returns {light1, light2} for a phase; every all-red phase shares one code.
  function automatic logic [5:0] lightPair(input state_t s);
    logic [5:0] pair;
    pair = {LT_RED, LT_RED};
    case (s)
      S_G1:    pair = {LT_GREEN, LT_RED};
      S_Y1:    pair = {LT_YELLOW, LT_RED};
      S_G2:    pair = {LT_RED, LT_GREEN};
      S_Y2:    pair = {LT_RED, LT_YELLOW};
      default: pair = {LT_RED, LT_RED};
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/traffic_sequencer_tick_gen.sv
// Prescaler producing a single-cycle tick every CLK_DIV clocks;
// hold freezes the count and suppresses the tick.
module tick_gen #(
  parameter int unsigned CLK_DIV = 125_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int unsigned W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count <= '0;
    end else if (!hold) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign tick = !hold && (r_count == LAST);

endmodule

// File: rtl/traffic_sequencer.sv
// Two-approach junction phase controller with pedestrian WALK insertion;
// rst_n is an active-high asynchronous reset.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 125_000_000,
  parameter int unsigned T_GREEN  = 8,
  parameter int unsigned T_YELLOW = 2,
  parameter int unsigned T_CLEAR  = 1,
  parameter int unsigned T_WALK   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       ped_req,
  output logic [2:0] light1,
  output logic [2:0] light2,
  output logic [7:0] count,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [7:0] LEN_GREEN  = 8'(T_GREEN);
  localparam logic [7:0] LEN_YELLOW = 8'(T_YELLOW);
  localparam logic [7:0] LEN_CLEAR  = 8'(T_CLEAR);
  localparam logic [7:0] LEN_WALK   = 8'(T_WALK);

  logic       w_tick;
  logic       w_accept;
  logic       w_expire;
  logic       w_divert;
  state_t     w_nextState;
  logic [7:0] w_nextLen;

  state_t     r_state;
  state_t     r_succ;
  logic [7:0] r_remain;
  logic       r_pending;
  logic       r_ack;
  logic [2:0] r_light1;
  logic [2:0] r_light2;
  logic [7:0] r_count;
  logic       r_walk;
  state_t     r_phase;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .tick  (w_tick)
  );

  // Pending is sampled before this cycle's request, so a request arriving on an all-red expiry waits.
  assign w_accept = ped_req && !r_pending && (r_state != S_WALK);
  assign w_expire = w_tick && (r_remain == 8'd1);

  always_comb begin
    w_nextState = S_R2;
    w_divert    = 1'b0;
    case (r_state)
      S_G1:   w_nextState = S_Y1;
      S_Y1:   w_nextState = S_R1;
      S_R1:   begin
        w_nextState = r_pending ? S_WALK : S_G2;
        w_divert    = r_pending;
      end
      S_G2:   w_nextState = S_Y2;
      S_Y2:   w_nextState = S_R2;
      S_R2:   begin
        w_nextState = r_pending ? S_WALK : S_G1;
        w_divert    = r_pending;
      end
      S_WALK: w_nextState = r_succ;
      default: w_nextState = S_R2;
    endcase
  end

  always_comb begin
    w_nextLen = LEN_CLEAR;
    case (w_nextState)
      S_G1, S_G2: w_nextLen = LEN_GREEN;
      S_Y1, S_Y2: w_nextLen = LEN_YELLOW;
      S_WALK:     w_nextLen = LEN_WALK;
      default:    w_nextLen = LEN_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= S_R2;
      r_succ    <= S_G1;
      r_remain  <= LEN_CLEAR;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_light1  <= LT_RED;
      r_light2  <= LT_RED;
      r_count   <= LEN_CLEAR;
      r_walk    <= 1'b0;
      r_phase   <= S_R2;
    end else begin
      r_ack <= w_accept;
      if (w_expire) begin
        r_state              <= w_nextState;
        r_remain             <= w_nextLen;
        r_count              <= w_nextLen;
        {r_light1, r_light2} <= lightPair(w_nextState);
        r_walk               <= (w_nextState == S_WALK);
        r_phase              <= w_nextState;
        if (w_divert) begin
          r_pending <= 1'b0;
          r_succ    <= (r_state == S_R1) ? S_G2 : S_G1;
        end
      end else if (w_tick) begin
        r_remain <= r_remain - 8'd1;
        r_count  <= r_remain - 8'd1;
      end
      if (w_accept) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign light1  = r_light1;
  assign light2  = r_light2;
  assign count   = r_count;
  assign walk    = r_walk;
  assign ped_ack = r_ack;
  assign phase   = r_phase;

endmodule
